// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port, filled at boot over a byte-serial
// load port (16-bit big-endian word count, then big-endian words). Holds the core until loaded.
module inst_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_byte_i,
  output logic        ld_ready_o,
  input  logic        reload_i,
  output logic        cpu_hold_o,
  output logic        boot_done_o,
  output logic        ovf_o
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  localparam logic [1:0] S_LEN_HI = 2'd0;
  localparam logic [1:0] S_LEN_LO = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [16:0] wptr_q, wptr_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic        ovf_q, ovf_d;
  logic        mem_we;
  logic        take;

  logic [31:0] mem_q [DEPTH];

  // Handshake: a byte moves when ld_valid_i && ld_ready_o at a rising edge;
  // a reload_i pulse in the same cycle wins and the byte is not consumed.
  assign ld_ready_o  = (state_q != S_RUN);
  assign boot_done_o = (state_q == S_RUN);
  assign cpu_hold_o  = !boot_done_o;
  assign ovf_o       = ovf_q;
  assign take        = ld_valid_i && ld_ready_o && !reload_i;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    mem_we  = 1'b0;
    if (reload_i) begin
      state_d = S_LEN_HI;
      len_d   = 16'd0;
      wptr_d  = 17'd0;
      bcnt_d  = 2'd0;
      ovf_d   = 1'b0;
    end else if (take) begin
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = ld_byte_i;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = ld_byte_i;
          wptr_d     = 17'd0;
          bcnt_d     = 2'd0;
          state_d    = ({len_q[15:8], ld_byte_i} == 16'd0) ? S_RUN : S_DATA;
        end
        S_DATA: begin
          if (bcnt_q != 2'd3) begin
            word_d = {word_q[15:0], ld_byte_i};
            bcnt_d = bcnt_q + 2'd1;
          end else begin
            // Words past the end of the array are dropped, never wrapped.
            if (wptr_q < DEPTH_W) mem_we = 1'b1;
            else                  ovf_d  = 1'b1;
            wptr_d = wptr_q + 17'd1;
            bcnt_d = 2'd0;
            if (wptr_q + 17'd1 == {1'b0, len_q}) state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LEN_HI;
      len_q   <= 16'd0;
      wptr_q  <= 17'd0;
      bcnt_q  <= 2'd0;
      word_q  <= 24'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= {word_q, ld_byte_i};
  end

  // Byte-offset bits are ignored; any set bit above the word index is out of range.
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_in_range;
  logic                  unused_addr_bits;
  assign rd_idx           = rom_addr_i[ADDR_WIDTH+1:2];
  assign rd_in_range      = ((rom_addr_i >> (ADDR_WIDTH + 2)) == 32'd0);
  assign unused_addr_bits = ^rom_addr_i[1:0];
  assign rom_data_o       = (boot_done_o && rom_ce_i && rd_in_range) ? mem_q[rd_idx] : NOP_WORD;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: byte-stream model (accepted bytes kept in a queue) checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_inst_rom_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_ready_o;
  logic        reload_i;
  logic        cpu_hold_o;
  logic        boot_done_o;
  logic        ovf_o;

  inst_rom_loader #(.ADDR_WIDTH(AW), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .rom_data_o(rom_data_o), .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i),
    .ld_ready_o(ld_ready_o), .reload_i(reload_i), .cpu_hold_o(cpu_hold_o),
    .boot_done_o(boot_done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bytes accepted since the last reset/reload, plus the expected memory image.
  logic [7:0]  img[$];
  logic [31:0] exp_mem[DEPTH];
  bit          exp_valid[DEPTH];
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_len();
    if (img.size() < 2) return 0;
    return int'({img[0], img[1]});
  endfunction

  function automatic bit m_run();
    return (img.size() >= 2) && (img.size() == 2 + 4 * m_len());
  endfunction

  task automatic model_clear();
    img.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    int k;
    if (!rst || reload_i) begin
      model_clear();
    end else if (ld_valid_i && !m_run()) begin
      img.push_back(ld_byte_i);
      n = img.size();
      if (n >= 6 && ((n - 2) % 4) == 0) begin
        k = (n - 6) / 4;
        if (k < DEPTH) begin
          exp_mem[k]   = {img[n-4], img[n-3], img[n-2], img[n-1]};
          exp_valid[k] = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      chk("cmp_ld_ready", {31'd0, ld_ready_o}, {31'd0, !m_run()});
      chk("cmp_boot_done", {31'd0, boot_done_o}, {31'd0, m_run()});
      chk("cmp_cpu_hold", {31'd0, cpu_hold_o}, {31'd0, !m_run()});
      chk("cmp_ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
      if (m_run() && rom_ce_i && ((rom_addr_i >> (AW + 2)) == 32'd0)) begin
        idx = int'(rom_addr_i[AW+1:2]);
        if (exp_valid[idx]) chk("cmp_rom", rom_data_o, exp_mem[idx]);
      end else begin
        chk("cmp_rom_nop", rom_data_o, 32'h0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    cycle();
    ld_valid_i = 1'b0;
  endtask

  task automatic reload();
    reload_i = 1'b1;
    cycle();
    reload_i = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    #1;
    chk(name, rom_data_o, exp);
  endtask

  task automatic async_reset();
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    chk("async_rst_hold", {31'd0, cpu_hold_o}, 32'd1);
    chk("async_rst_boot", {31'd0, boot_done_o}, 32'd0);
    chk("async_rst_ready", {31'd0, ld_ready_o}, 32'd1);
    chk("async_rst_rom", rom_data_o, 32'h0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  logic [7:0] img1 [10];

  initial begin
    rst        = 1'b0;
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'd0;
    ld_valid_i = 1'b0;
    ld_byte_i  = 8'd0;
    reload_i   = 1'b0;
    model_clear();
    #1;
    chk("reset_ready", {31'd0, ld_ready_o}, 32'd1);
    chk("reset_hold", {31'd0, cpu_hold_o}, 32'd1);
    chk("reset_boot", {31'd0, boot_done_o}, 32'd0);
    chk("reset_ovf", {31'd0, ovf_o}, 32'd0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // Two-word image
    img1 = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("img1_boot_before_last", {31'd0, boot_done_o}, 32'd0);
      send_byte(img1[i]);
    end
    chk("img1_boot_done", {31'd0, boot_done_o}, 32'd1);
    chk("img1_hold_low", {31'd0, cpu_hold_o}, 32'd0);
    fetch("img1_addr0", 32'd0, 32'h3401_0010);
    fetch("img1_addr4", 32'd4, 32'h3402_0020);
    fetch("img1_addr5", 32'd5, 32'h3402_0020);
    cycle();
    rom_ce_i = 1'b0;
    #1;
    chk("ce_low_nop", rom_data_o, 32'h0);
    fetch("idx1024_nop", 32'h0000_1000, 32'h0);
    fetch("high_bit_nop", 32'h8000_0004, 32'h0);
    cycle();

    // Zero count: straight to run, later bytes ignored
    reload();
    send_byte(8'h00);
    send_byte(8'h00);
    chk("zero_len_boot", {31'd0, boot_done_o}, 32'd1);
    chk("zero_len_ready", {31'd0, ld_ready_o}, 32'd0);
    for (int i = 0; i < 6; i++) send_byte(8'hAB);
    fetch("zero_len_mem0", 32'd0, 32'h3401_0010);
    fetch("zero_len_mem1", 32'd4, 32'h3402_0020);
    cycle();

    // Overflow: DEPTH+1 words of all ones
    reload();
    chk("reload_not_run", {31'd0, boot_done_o}, 32'd0);
    send_byte(8'h04);
    send_byte(8'h01);
    for (int i = 0; i < 4 * (DEPTH + 1); i++) begin
      if (i == 4 * (DEPTH + 1) - 1) begin
        chk("ovf_before_drop", {31'd0, ovf_o}, 32'd0);
        chk("ovf_boot_before_4102", {31'd0, boot_done_o}, 32'd0);
      end
      send_byte(8'hFF);
    end
    chk("ovf_set", {31'd0, ovf_o}, 32'd1);
    chk("ovf_boot_at_4102", {31'd0, boot_done_o}, 32'd1);
    fetch("ovf_mem0", 32'd0, 32'hFFFF_FFFF);
    fetch("ovf_mem_last", 32'd4092, 32'hFFFF_FFFF);
    cycle();

    // Reload in the middle of a data word, colliding with an offered byte
    reload();
    chk("reload_clears_ovf", {31'd0, ovf_o}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h12);
    send_byte(8'h34);
    reload_i   = 1'b1;
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'h99;
    cycle();
    reload_i   = 1'b0;
    ld_valid_i = 1'b0;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    chk("collide_not_run_yet", {31'd0, boot_done_o}, 32'd0);
    send_byte(8'hDD);
    chk("collide_run", {31'd0, boot_done_o}, 32'd1);
    fetch("collide_mem0", 32'd0, 32'hAABB_CCDD);
    cycle();

    // Asynchronous reset mid-data, then a fresh one-word image
    rom_ce_i = 1'b0;
    reload();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h55);
    send_byte(8'h66);
    async_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("rst_reload_boot", {31'd0, boot_done_o}, 32'd1);
    fetch("rst_reload_mem0", 32'd0, 32'h1122_3344);
    cycle();

    // Asynchronous reset while running drops boot_done without a clock edge
    rom_ce_i = 1'b1;
    async_reset();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
Instruction-memory responder for the core's instruction fetch port. It answers rom_ce/rom_addr with rom_data, combinationally, in the same cycle. At boot it is filled over a byte-serial load port: a 16-bit word count followed by big-endian instruction words. It holds the core in reset until loading completes.

Parameters:
ADDR_WIDTH, 10, word-index bits; memory depth DEPTH = 2**ADDR_WIDTH 32-bit words
NOP_WORD, 32'h00000000, value returned when no valid instruction is available

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
rom_ce_i  in  1  fetch enable from the core's pc stage
rom_addr_i  in  32  byte address from the core's pc; word index = rom_addr_i[ADDR_WIDTH+1:2]
rom_data_o  out  32  instruction word to the IF/ID stage
ld_valid_i  in  1  load byte strobe; a byte is taken when ld_valid_i && ld_ready_o at a clock edge
ld_byte_i  in  8  load byte
ld_ready_o  out  1  loader can accept a byte
reload_i  in  1  one-cycle pulse that restarts the load sequence
cpu_hold_o  out  1  high keeps the core in reset; drives the core's reset qualifier
boot_done_o  out  1  high in RUN
ovf_o  out  1  sticky; set when the word count exceeds DEPTH

Behaviour:
- State machine states: S_LEN_HI, S_LEN_LO, S_DATA, S_RUN.
- Reset (rst=0, asynchronous):
  - state=S_LEN_HI; len=0; wptr=0; bcnt=0; ovf_o=0.
  - Memory array is not reset.
- ld_ready_o = 1 in S_LEN_HI, S_LEN_LO and S_DATA; 0 in S_RUN.
- cpu_hold_o = !boot_done_o. boot_done_o = (state==S_RUN).
- S_LEN_HI: on an accepted byte, len[15:8] <= byte, then go to S_LEN_LO.
- S_LEN_LO: on an accepted byte, len[7:0] <= byte.
  - If {len[15:8], byte} == 0, go directly to S_RUN.
  - Otherwise go to S_DATA with wptr=0, bcnt=0.
- S_DATA: bytes are assembled big-endian.
  - The first byte of a word goes to bits [31:24]; bcnt counts 0..3.
  - On the 4th byte (bcnt==3), the word {b0,b1,b2,b3} is written to mem[wptr] if wptr < DEPTH. If wptr >= DEPTH, the word is dropped and ovf_o <= 1.
  - Also on the 4th byte: wptr <= wptr+1 (17-bit counter, no wrap) and bcnt <= 0.
  - If wptr+1 == len, go to S_RUN at that same edge. The last word is readable in the first S_RUN cycle.
- S_RUN: ld_valid_i is ignored and no bytes are consumed.
- reload_i (any state, synchronous): state <= S_LEN_HI; wptr, bcnt and len are cleared.
  - ovf_o is cleared.
  - Memory contents are retained.
  - If a byte is offered in the same cycle as reload_i, reload wins and the byte is not taken.
- Fetch read (combinational):
  - rom_data_o = mem[idx] when state==S_RUN && rom_ce_i==1 && idx < DEPTH.
  - In all other cases rom_data_o = NOP_WORD.
  - rom_addr_i[1:0] are ignored (misaligned addresses are truncated).
  - Upper address bits above ADDR_WIDTH+1 must be zero; otherwise the fetch is out of range and returns NOP_WORD.
- Read vs write collision: it cannot occur, because reads are only valid in S_RUN and writes only occur in S_DATA.
- Reset mid-load: partial word is discarded; core stays held; the sequence restarts at S_LEN_HI.
- While in S_LEN_HI, S_LEN_LO or S_DATA, rom_data_o = NOP_WORD regardless of rom_ce_i. The held core therefore fetches NOPs even if it leaves reset early.

Test Plan:
- Reset, then send 00 02 34 01 00 10 34 02 00 20. Required:
  - boot_done_o rises at the edge of the 10th byte; cpu_hold_o falls.
  - rom_addr_i=0 gives 32'h34010010; rom_addr_i=4 gives 32'h34020020; rom_addr_i=5 gives 32'h34020020.
- Count 00 00: goes to S_RUN immediately after the 2nd byte. ld_ready_o=0 thereafter; further bytes are ignored and memory is unchanged.
- In S_RUN with rom_ce_i=0: rom_data_o=0. With rom_ce_i=1 and rom_addr_i=32'h00001000 (idx=1024, ADDR_WIDTH=10): rom_data_o=0.
- Count DEPTH+1 = 16'h0401 with all words 32'hFFFFFFFF:
  - ovf_o=1 after word 1024 is dropped.
  - mem[0] is not overwritten.
  - S_RUN is reached after 4102 bytes total.
- Load 2 bytes of a data word, assert reload_i together with a byte, then send the count 00 01 and word AABBCCDD. Required: the byte with reload is not taken; result is mem[0]=32'hAABBCCDD and S_RUN.
- Assert rst low mid-S_DATA, release, reload the 1-word image 11223344. Required: outputs are reset immediately (asynchronously), cpu_hold_o=1, then normal load completes and fetch at 0 returns 32'h11223344.
